// File: rtl/riscv.sv
// Shared Sv39 address constants and the TLB fill/refill record exchanged
// between the page-table walker, the L1 TLB and the L2 TLB.
package riscv;

    localparam int unsigned VLEN     = 39;
    localparam int unsigned PPNW     = 44;
    localparam int unsigned ASID_LEN = 16;

    typedef struct packed {
        logic [9:0]      reserved;
        logic [PPNW-1:0] ppn;
        logic [1:0]      rsw;
        logic            d;
        logic            a;
        logic            g;
        logic            u;
        logic            x;
        logic            w;
        logic            r;
        logic            v;
    } pte_t;

    typedef struct packed {
        logic                valid;
        logic                is_2M;
        logic                is_1G;
        logic [26:0]         vpn;
        logic [ASID_LEN-1:0] asid;
        pte_t                content;
    } tlb_update_t;

endpackage

// File: rtl/l2_tlb.sv
// Set-associative second-level TLB for 4 KB leaves: fixed two-cycle lookup
// (READ then COMPARE), PTW fills with invalid-first / round-robin replacement.
module l2_tlb #(
    parameter int unsigned L2_TLB_SETS = 16,
    parameter int unsigned L2_TLB_WAYS = 4,
    parameter int unsigned ASID_WIDTH  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    req_i,
    input  logic [ASID_WIDTH-1:0]   req_asid_i,
    input  logic [riscv::VLEN-1:0]  req_vaddr_i,
    output logic                    ready_o,
    input  riscv::tlb_update_t      ptw_update_i,
    output logic                    hit_o,
    output riscv::tlb_update_t      update_o,
    output logic                    miss_o
);

    localparam int unsigned IDX_W = $clog2(L2_TLB_SETS);
    localparam int unsigned WAY_W = $clog2(L2_TLB_WAYS);

    typedef enum logic [1:0] {IDLE, READ, COMPARE} state_e;

    typedef struct packed {
        logic [ASID_WIDTH-1:0] asid;
        logic [26:0]           vpn;
        logic                  valid;
    } tag_t;

    tag_t         tag_q     [L2_TLB_SETS][L2_TLB_WAYS];
    riscv::pte_t  content_q [L2_TLB_SETS][L2_TLB_WAYS];
    logic [WAY_W-1:0] rr_q  [L2_TLB_SETS];

    state_e                state_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic [26:0]           vpn_q;
    tag_t                  rd_tag_q     [L2_TLB_WAYS];
    riscv::pte_t           rd_content_q [L2_TLB_WAYS];

    logic              fill_en;
    logic              fill_advance;
    logic [IDX_W-1:0]  fill_set;
    logic [WAY_W-1:0]  fill_way;
    logic [ASID_WIDTH-1:0] fill_asid;
    logic              dup_found;
    logic [WAY_W-1:0]  dup_way;
    logic              free_found;
    logic [WAY_W-1:0]  free_way;
    logic              hit_found;
    logic [WAY_W-1:0]  hit_way;
    logic              in_compare;

    logic unused_bits;
    assign unused_bits = ^{req_vaddr_i[11:0], ptw_update_i.asid};

    assign ready_o = (state_q == IDLE) && !flush_i;

    // Fill way selection: an existing translation is refreshed in place, else the
    // lowest free way, else the round-robin victim.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fill_set   = ptw_update_i.vpn[IDX_W-1:0];
        fill_asid  = ptw_update_i.asid[ASID_WIDTH-1:0];
        fill_en    = ptw_update_i.valid && !ptw_update_i.is_2M && !ptw_update_i.is_1G && !flush_i;
        dup_found  = 1'b0;
        dup_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < int'(L2_TLB_WAYS); w++) begin
            if (!dup_found && tag_q[fill_set][w].valid &&
                tag_q[fill_set][w].vpn == ptw_update_i.vpn &&
                tag_q[fill_set][w].asid == fill_asid) begin
                dup_found = 1'b1;
                dup_way   = WAY_W'(w);
            end
            if (!free_found && !tag_q[fill_set][w].valid) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
        fill_advance = fill_en && !dup_found && !free_found;
        fill_way     = dup_found ? dup_way : (free_found ? free_way : rr_q[fill_set]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the arrays are architecturally reset (valid, tags, content, pointers), so
        // they map to flops rather than a RAM macro; keep the array small.
        if (!rst_ni) begin
            for (int s = 0; s < int'(L2_TLB_SETS); s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < int'(L2_TLB_WAYS); w++) begin
                    tag_q[s][w]     <= '0;
                    content_q[s][w] <= '0;
                end
            end
        end else if (flush_i) begin
            // Flush wins over a concurrent fill and leaves the pointers alone.
            for (int s = 0; s < int'(L2_TLB_SETS); s++) begin
                for (int w = 0; w < int'(L2_TLB_WAYS); w++) begin
                    tag_q[s][w].valid <= 1'b0;
                end
            end
        end else if (fill_en) begin
            tag_q[fill_set][fill_way]     <= '{asid: fill_asid, vpn: ptw_update_i.vpn, valid: 1'b1};
            content_q[fill_set][fill_way] <= ptw_update_i.content;
            if (fill_advance) begin
                rr_q[fill_set] <= rr_q[fill_set] + WAY_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            asid_q  <= '0;
            vpn_q   <= '0;
            for (int w = 0; w < int'(L2_TLB_WAYS); w++) begin
                rd_tag_q[w]     <= '0;
                rd_content_q[w] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && ready_o) begin
                        asid_q  <= req_asid_i;
                        vpn_q   <= req_vaddr_i[38:12];
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        for (int w = 0; w < int'(L2_TLB_WAYS); w++) begin
                            rd_tag_q[w]     <= tag_q[vpn_q[IDX_W-1:0]][w];
                            rd_content_q[w] <= content_q[vpn_q[IDX_W-1:0]][w];
                        end
                        state_q <= COMPARE;
                    end
                end
                COMPARE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Global pages match regardless of ASID; the lowest matching way wins.
    always_comb begin
        hit_found = 1'b0;
        hit_way   = '0;
        for (int w = 0; w < int'(L2_TLB_WAYS); w++) begin
            if (!hit_found && rd_tag_q[w].valid && rd_tag_q[w].vpn == vpn_q &&
                (rd_tag_q[w].asid == asid_q || rd_content_q[w].g)) begin
                hit_found = 1'b1;
                hit_way   = WAY_W'(w);
            end
        end
    end

    assign in_compare = (state_q == COMPARE) && !flush_i;
    assign hit_o      = in_compare && hit_found;
    assign miss_o     = in_compare && !hit_found;

    always_comb begin
        update_o = '0;
        if (hit_o) begin
            update_o.valid                   = 1'b1;
            update_o.vpn                     = vpn_q;
            update_o.asid[ASID_WIDTH-1:0]    = asid_q;
            update_o.content                 = rd_content_q[hit_way];
        end
    end

endmodule

// File: tb/tb_l2_tlb.sv
// Scoreboard bench for l2_tlb: directed lookups/fills push expected responses,
// a negedge monitor pops and compares every hit/miss pulse.
module tb_l2_tlb;

    logic                   clk_i;
    logic                   rst_ni;
    logic                   flush_i;
    logic                   req_i;
    logic [1:0]             req_asid_i;
    logic [riscv::VLEN-1:0] req_vaddr_i;
    logic                   ready_o;
    riscv::tlb_update_t     ptw_update_i;
    logic                   hit_o;
    riscv::tlb_update_t     update_o;
    logic                   miss_o;

    l2_tlb #(.L2_TLB_SETS(16), .L2_TLB_WAYS(4), .ASID_WIDTH(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .req_i        (req_i),
        .req_asid_i   (req_asid_i),
        .req_vaddr_i  (req_vaddr_i),
        .ready_o      (ready_o),
        .ptw_update_i (ptw_update_i),
        .hit_o        (hit_o),
        .update_o     (update_o),
        .miss_o       (miss_o)
    );

    typedef struct {
        bit          hit;
        logic [26:0] vpn;
        logic [15:0] asid;
        logic [43:0] ppn;
        bit          g;
        longint      cyc;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     n_pass = 0;
    int     n_total = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (!hit_o) check("update_zero", 128'(update_o), 128'(0));
            if (hit_o || miss_o) begin
                check("pulse_expected", 128'(sb.size() != 0), 128'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", 128'(cyc), 128'(e.cyc));
                    check("hit", 128'(hit_o), 128'(e.hit));
                    check("miss", 128'(miss_o), 128'(!e.hit));
                    if (e.hit) begin
                        check("upd_valid", 128'(update_o.valid), 128'(1));
                        check("upd_size", 128'({update_o.is_2M, update_o.is_1G}), 128'(0));
                        check("upd_vpn", 128'(update_o.vpn), 128'(e.vpn));
                        check("upd_asid", 128'(update_o.asid), 128'(e.asid));
                        check("upd_ppn", 128'(update_o.content.ppn), 128'(e.ppn));
                        check("upd_g", 128'(update_o.content.g), 128'(e.g));
                    end
                end
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the accept edge (lookup now in READ).
    task automatic lookup(input logic [26:0] vpn, input logic [1:0] asid, input bit exp_hit,
                          input logic [43:0] ppn, input bit g, input bit expect_pulse);
        bit accepted = 1'b0;
        bit rdy;
        exp_t e;
        req_vaddr_i = {vpn, 12'h000};
        req_asid_i  = asid;
        req_i       = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk_i);
            rdy = ready_o;
            @(posedge clk_i);
            if (rdy) accepted = 1'b1;
        end
        check("accept", 128'(accepted), 128'(1));
        if (accepted && expect_pulse) begin
            e.hit  = exp_hit;
            e.vpn  = vpn;
            e.asid = {14'b0, asid};
            e.ppn  = ppn;
            e.g    = g;
            e.cyc  = cyc + 2;
            sb.push_back(e);
        end
        #1;
        req_i = 1'b0;
    endtask

    task automatic fill(input logic [26:0] vpn, input logic [1:0] asid, input logic [43:0] ppn,
                        input bit g, input bit is_2m);
        riscv::tlb_update_t u;
        u             = '0;
        u.valid       = 1'b1;
        u.is_2M       = is_2m;
        u.vpn         = vpn;
        u.asid        = {14'b0, asid};
        u.content.ppn = ppn;
        u.content.g   = g;
        u.content.v   = 1'b1;
        ptw_update_i  = u;
        @(posedge clk_i);
        #1;
        ptw_update_i = '0;
    endtask

    initial begin
        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        req_i        = 1'b0;
        req_asid_i   = '0;
        req_vaddr_i  = '0;
        ptw_update_i = '0;

        @(negedge clk_i);
        check("rst_hit", 128'(hit_o), 128'(0));
        check("rst_miss", 128'(miss_o), 128'(0));
        check("rst_update", 128'(update_o), 128'(0));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("ready_after_reset", 128'(ready_o), 128'(1));
        settle(1);

        // Cold lookup of 0x4000_1000 misses.
        lookup(27'h40001, 2'd1, 1'b0, 44'h0, 1'b0, 1'b1);
        settle(3);

        // Fill then hit; other ASID misses unless global.
        fill(27'h40001, 2'd1, 44'h80123, 1'b0, 1'b0);
        lookup(27'h40001, 2'd1, 1'b1, 44'h80123, 1'b0, 1'b1);
        lookup(27'h40001, 2'd2, 1'b0, 44'h0, 1'b0, 1'b1);
        settle(3);
        fill(27'h40002, 2'd1, 44'h80456, 1'b1, 1'b0);
        lookup(27'h40002, 2'd2, 1'b1, 44'h80456, 1'b1, 1'b1);
        settle(3);

        // Superpage fills are dropped.
        fill(27'h40003, 2'd1, 44'h80789, 1'b0, 1'b1);
        lookup(27'h40003, 2'd1, 1'b0, 44'h0, 1'b0, 1'b1);
        settle(3);

        // Flush during READ aborts the lookup and wipes all entries.
        lookup(27'h40001, 2'd1, 1'b0, 44'h0, 1'b0, 1'b0);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_flush", 128'(ready_o), 128'(1));
        settle(1);
        lookup(27'h40001, 2'd1, 1'b0, 44'h0, 1'b0, 1'b1);
        lookup(27'h40002, 2'd2, 1'b0, 44'h0, 1'b0, 1'b1);
        settle(3);

        // Set 0 replacement: four free ways, then round-robin from way 0.
        for (int k = 1; k <= 5; k++) fill(27'(k * 16), 2'd1, 44'(32'h1000 + k), 1'b0, 1'b0);
        lookup(27'h10, 2'd1, 1'b0, 44'h0, 1'b0, 1'b1);
        lookup(27'h20, 2'd1, 1'b1, 44'h1002, 1'b0, 1'b1);
        lookup(27'h50, 2'd1, 1'b1, 44'h1005, 1'b0, 1'b1);
        settle(3);
        fill(27'h60, 2'd1, 44'h1006, 1'b0, 1'b0);
        lookup(27'h20, 2'd1, 1'b0, 44'h0, 1'b0, 1'b1);
        lookup(27'h30, 2'd1, 1'b1, 44'h1003, 1'b0, 1'b1);
        settle(3);
        // Refresh in place keeps the pointer at way 2, so 0x70 evicts 0x30, not 0x40.
        fill(27'h30, 2'd1, 44'h2003, 1'b0, 1'b0);
        lookup(27'h30, 2'd1, 1'b1, 44'h2003, 1'b0, 1'b1);
        settle(3);
        fill(27'h70, 2'd1, 44'h1007, 1'b0, 1'b0);
        lookup(27'h30, 2'd1, 1'b0, 44'h0, 1'b0, 1'b1);
        lookup(27'h40, 2'd1, 1'b1, 44'h1004, 1'b0, 1'b1);
        lookup(27'h70, 2'd1, 1'b1, 44'h1007, 1'b0, 1'b1);
        settle(3);

        // Fill landing in the READ cycle is not seen by that lookup.
        lookup(27'h123, 2'd1, 1'b0, 44'h0, 1'b0, 1'b1);
        fill(27'h123, 2'd1, 44'h3123, 1'b0, 1'b0);
        settle(3);
        lookup(27'h123, 2'd1, 1'b1, 44'h3123, 1'b0, 1'b1);
        settle(3);

        // Reset mid-lookup: no pulse, contents cleared.
        lookup(27'h123, 2'd1, 1'b0, 44'h0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst_hit", 128'(hit_o), 128'(0));
        check("midrst_miss", 128'(miss_o), 128'(0));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("ready_after_midrst", 128'(ready_o), 128'(1));
        settle(1);
        lookup(27'h123, 2'd1, 1'b0, 44'h0, 1'b0, 1'b1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk_i);
        @(negedge clk_i);
        check("scoreboard_drained", 128'(sb.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
